// File: rtl/score_display_defs.sv
// Shared constants and helpers for the score display: segment patterns,
// digit geometry, conversion FSM states and the BCD adjust step.
package score_display_defs;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 16;
    localparam int unsigned SRC_W      = 14;

    // Active-low cathodes, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_e;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with a committed output
// register; a start seen during COMMIT chains straight into the next run.
module bin2bcd_seq
    import score_display_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [SRC_W-1:0] src_i,
    input  logic             ovf_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o,
    output logic             ovf_o
);

    localparam logic [3:0] SHIFT_LAST = 4'(SRC_W - 1);

    conv_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic             ovfn_q, ovfn_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            acc_q   <= '0;
            disp_q  <= '0;
            ovfn_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            acc_q   <= acc_d;
            disp_q  <= disp_d;
            ovfn_q  <= ovfn_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        acc_d   = acc_q;
        disp_d  = disp_q;
        ovfn_d  = ovfn_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            CONV_IDLE: ;
            CONV_SHIFT: begin
                acc_d = (bcd_add3(acc_q) << 1) | BCD_W'(src_q[SRC_W-1]);
                src_d = src_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SHIFT_LAST) state_d = CONV_COMMIT;
            end
            CONV_COMMIT: begin
                disp_d  = acc_q;
                ovf_d   = ovfn_q;
                state_d = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
        // Capture is shared by IDLE and COMMIT so back-to-back runs have no gap.
        if (start_i && state_q != CONV_SHIFT) begin
            src_d   = src_i;
            ovfn_d  = ovf_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONV_SHIFT;
        end
    end

    assign busy_o = (state_q != CONV_IDLE);
    assign done_o = (state_q == CONV_COMMIT);
    assign bcd_o  = disp_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/score_display_scanner.sv
// Four-digit decimal score display: saturates and converts the score to BCD,
// holds one pending update while busy, and scans digits onto seg/an.
module score_display_scanner
    import score_display_defs::*;
#(
    parameter int unsigned REFRESH_CLKS  = 50000,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter int unsigned MAX_DISPLAY   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned    RW      = $clog2(REFRESH_CLKS);
    localparam logic [RW-1:0]  RLAST   = RW'(REFRESH_CLKS - 1);
    localparam logic [15:0]    MAX_V   = 16'(MAX_DISPLAY);
    localparam logic [SRC_W-1:0] MAX_SRC = SRC_W'(MAX_DISPLAY);

    logic             pend_q, pend_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic             start;
    logic [15:0]      start_val;
    logic [SRC_W-1:0] start_src;
    logic             start_ovf;
    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] disp;

    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [BCD_W-1:0] upper;
    logic             blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            rcnt_q     <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            rcnt_q     <= rcnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // A strobe landing on COMMIT is the newest value, so it beats any pending one.
    always_comb begin
        start      = 1'b0;
        start_val  = value;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (conv_done) begin
            start     = value_valid || pend_q;
            start_val = value_valid ? value : pend_val_q;
            pend_d    = 1'b0;
        end else if (value_valid && conv_busy) begin
            pend_d     = 1'b1;
            pend_val_d = value;
        end else if (value_valid) begin
            start = 1'b1;
        end
        start_ovf = (start_val > MAX_V);
        start_src = start_ovf ? MAX_SRC : start_val[SRC_W-1:0];
    end

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .src_i   (start_src),
        .ovf_i   (start_ovf),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (disp),
        .ovf_o   (overflow)
    );

    always_comb begin
        rcnt_d = (rcnt_q == RLAST) ? '0 : rcnt_q + 1'b1;
        idx_d  = (rcnt_q == RLAST) ? idx_q + 2'd1 : idx_q;
        upper  = disp >> {idx_q, 2'b00};
        blank  = BLANK_LEADING && (idx_q != 2'd0) && (upper == '0);
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = blank ? SEG_BLANK : seg_pattern(disp[{idx_q, 2'b00} +: 4]);
    end

    assign busy = conv_busy;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
